lsu_port_arbiter: RTL and testbench

- Shares the single data-memory port between the two superscalar issue slots (slot 0, slot 1).
- Arbitrates load/store requests round-robin, drives one aligned memory transaction at a time and waits for a variable-latency acknowledge.
- Lane-aligns returned load data and sign/zero-extends it per load opcode; forms byte enables and replicated write data for stores.
- Returns a tagged one-cycle response to the writeback stage of the owning slot.

---
 rtl/lsu_port_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_lsu_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_port_arbiter.sv
// rtl/lsu_port_arbiter.sv - two-slot load/store port arbiter onto a single data-memory port
module lsu_port_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int TWIDTH       = 5,
  parameter int OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_LOAD_BYTE          = 'h0,
  parameter logic [OPCODE_WIDTH-1:0] OP_LOAD_HALF          = 'h1,
  parameter logic [OPCODE_WIDTH-1:0] OP_LOAD_WORD          = 'h2,
  parameter logic [OPCODE_WIDTH-1:0] OP_LOAD_BYTE_UNSIGNED = 'h4,
  parameter logic [OPCODE_WIDTH-1:0] OP_LOAD_HALF_UNSIGNED = 'h5,
  parameter logic [OPCODE_WIDTH-1:0] OP_STORE_BYTE         = 'h8,
  parameter logic [OPCODE_WIDTH-1:0] OP_STORE_HALF         = 'h9,
  parameter logic [OPCODE_WIDTH-1:0] OP_STORE_WORD         = 'hA
) (
  input  logic                    ls_i_clk,
  input  logic                    ls_i_rst,
  input  logic                    ls_i_valid0,
  input  logic                    ls_i_valid1,
  output logic                    ls_o_ready0,
  output logic                    ls_o_ready1,
  input  logic [OPCODE_WIDTH-1:0] ls_i_opcode0,
  input  logic [OPCODE_WIDTH-1:0] ls_i_opcode1,
  input  logic [AWIDTH-1:0]       ls_i_addr0,
  input  logic [AWIDTH-1:0]       ls_i_addr1,
  input  logic [DWIDTH-1:0]       ls_i_wdata0,
  input  logic [DWIDTH-1:0]       ls_i_wdata1,
  input  logic [TWIDTH-1:0]       ls_i_tag0,
  input  logic [TWIDTH-1:0]       ls_i_tag1,
  output logic                    ls_o_mem_req,
  output logic                    ls_o_mem_we,
  output logic [AWIDTH-1:0]       ls_o_mem_addr,
  output logic [3:0]              ls_o_mem_be,
  output logic [DWIDTH-1:0]       ls_o_mem_wdata,
  input  logic                    ls_i_mem_ack,
  input  logic [DWIDTH-1:0]       ls_i_mem_rdata,
  output logic                    ls_o_resp_valid,
  output logic                    ls_o_resp_slot,
  output logic [TWIDTH-1:0]       ls_o_resp_tag,
  output logic [DWIDTH-1:0]       ls_o_resp_data,
  output logic                    ls_o_resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t state_q, state_d;
  logic   ptr_q;

  // request selection
  logic                    any_valid;
  logic                    grant_slot;
  logic                    accept;
  logic [OPCODE_WIDTH-1:0] sel_op;
  logic [AWIDTH-1:0]       sel_addr;
  logic [DWIDTH-1:0]       sel_wdata;
  logic [TWIDTH-1:0]       sel_tag;

  // opcode decode of the selected request
  logic       dec_load;
  logic       dec_store;
  logic       dec_unsigned;
  logic [1:0] dec_size;
  logic       dec_err;
  logic [1:0] sel_off;
  logic [3:0] sel_be;
  logic [DWIDTH-1:0] sel_wrep;

  // latched transaction
  logic              slot_q;
  logic [TWIDTH-1:0] tag_q;
  logic [AWIDTH-1:0] addr_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] data_q;
  logic              err_q;

  // load extraction
  logic [DWIDTH-1:0] rd_shifted;
  logic [DWIDTH-1:0] rd_ext;

  // Round-robin grant: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    any_valid = ls_i_valid0 | ls_i_valid1;
    if (ls_i_valid0 && !ls_i_valid1) begin
      grant_slot = 1'b0;
    end else if (ls_i_valid1 && !ls_i_valid0) begin
      grant_slot = 1'b1;
    end else begin
      grant_slot = ptr_q;
    end
    accept    = (state_q == S_IDLE) && !ls_i_rst && any_valid;
    sel_op    = grant_slot ? ls_i_opcode1 : ls_i_opcode0;
    sel_addr  = grant_slot ? ls_i_addr1   : ls_i_addr0;
    sel_wdata = grant_slot ? ls_i_wdata1  : ls_i_wdata0;
    sel_tag   = grant_slot ? ls_i_tag1    : ls_i_tag0;
  end

  // Decode the granted opcode and flag misaligned or unknown accesses.
  always_comb begin
    dec_load     = 1'b0;
    dec_store    = 1'b0;
    dec_unsigned = 1'b0;
    dec_size     = SZ_WORD;
    case (sel_op)
      OP_LOAD_BYTE:          begin dec_load  = 1'b1; dec_size = SZ_BYTE; end
      OP_LOAD_BYTE_UNSIGNED: begin dec_load  = 1'b1; dec_size = SZ_BYTE; dec_unsigned = 1'b1; end
      OP_LOAD_HALF:          begin dec_load  = 1'b1; dec_size = SZ_HALF; end
      OP_LOAD_HALF_UNSIGNED: begin dec_load  = 1'b1; dec_size = SZ_HALF; dec_unsigned = 1'b1; end
      OP_LOAD_WORD:          begin dec_load  = 1'b1; dec_size = SZ_WORD; end
      OP_STORE_BYTE:         begin dec_store = 1'b1; dec_size = SZ_BYTE; end
      OP_STORE_HALF:         begin dec_store = 1'b1; dec_size = SZ_HALF; end
      OP_STORE_WORD:         begin dec_store = 1'b1; dec_size = SZ_WORD; end
      default:               begin dec_load  = 1'b0; dec_store = 1'b0; end
    endcase
    sel_off = sel_addr[1:0];
    if (!dec_load && !dec_store) begin
      dec_err = 1'b1;
    end else if (dec_size == SZ_HALF) begin
      dec_err = sel_off[0];
    end else if (dec_size == SZ_WORD) begin
      dec_err = (sel_off != 2'b00);
    end else begin
      dec_err = 1'b0;
    end
  end

  // Store lane formation; loads present no byte enables and zero write data.
  always_comb begin
    sel_be   = 4'b0000;
    sel_wrep = '0;
    if (dec_store) begin
      case (dec_size)
        SZ_BYTE: begin sel_be = 4'b0001 << sel_off; sel_wrep = {4{sel_wdata[7:0]}};  end
        SZ_HALF: begin sel_be = 4'b0011 << sel_off; sel_wrep = {2{sel_wdata[15:0]}}; end
        default: begin sel_be = 4'b1111;            sel_wrep = sel_wdata;            end
      endcase
    end
  end

  // Shift the returned word down to the accessed lane and extend per opcode.
  always_comb begin
    rd_shifted = ls_i_mem_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: rd_ext = unsigned_q ? {24'h0, rd_shifted[7:0]}
                                   : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_HALF: rd_ext = unsigned_q ? {16'h0, rd_shifted[15:0]}
                                   : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: rd_ext = rd_shifted;
    endcase
  end

  // State register; reset returns to IDLE and abandons any transaction in flight.
  always_ff @(posedge ls_i_clk) begin
    if (ls_i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: bad requests skip the memory and respond straight away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = dec_err ? S_RESP : S_MEM;
        end
      end
      S_MEM: begin
        if (ls_i_mem_ack) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: memory side is live only in MEM, response side only in RESP.
  always_comb begin
    ls_o_ready0     = accept && !grant_slot;
    ls_o_ready1     = accept &&  grant_slot;
    ls_o_mem_req    = (state_q == S_MEM);
    ls_o_mem_we     = 1'b0;
    ls_o_mem_addr   = '0;
    ls_o_mem_be     = 4'b0000;
    ls_o_mem_wdata  = '0;
    ls_o_resp_valid = (state_q == S_RESP);
    ls_o_resp_slot  = 1'b0;
    ls_o_resp_tag   = '0;
    ls_o_resp_data  = '0;
    ls_o_resp_err   = 1'b0;
    if (state_q == S_MEM) begin
      ls_o_mem_we    = we_q;
      ls_o_mem_addr  = addr_q;
      ls_o_mem_be    = be_q;
      ls_o_mem_wdata = wdata_q;
    end
    if (state_q == S_RESP) begin
      ls_o_resp_slot = slot_q;
      ls_o_resp_tag  = tag_q;
      ls_o_resp_data = data_q;
      ls_o_resp_err  = err_q;
    end
  end

  // Transaction registers: latch on accept, capture load data on ack.
  always_ff @(posedge ls_i_clk) begin
    if (ls_i_rst) begin
      ptr_q      <= 1'b0;
      slot_q     <= 1'b0;
      tag_q      <= '0;
      addr_q     <= '0;
      off_q      <= 2'b00;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q      <= ~grant_slot;
        slot_q     <= grant_slot;
        tag_q      <= sel_tag;
        addr_q     <= {sel_addr[AWIDTH-1:2], 2'b00};
        off_q      <= sel_off;
        size_q     <= dec_size;
        unsigned_q <= dec_unsigned;
        we_q       <= dec_store;
        be_q       <= sel_be;
        wdata_q    <= sel_wrep;
        data_q     <= '0;
        err_q      <= dec_err;
      end
      if ((state_q == S_MEM) && ls_i_mem_ack) begin
        data_q <= we_q ? '0 : rd_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb/tb_lsu_port_arbiter.sv - scoreboard bench for lsu_port_arbiter
module tb_lsu_port_arbiter;

  localparam logic [3:0] LB  = 4'h0;
  localparam logic [3:0] LH  = 4'h1;
  localparam logic [3:0] LW  = 4'h2;
  localparam logic [3:0] LBU = 4'h4;
  localparam logic [3:0] LHU = 4'h5;
  localparam logic [3:0] SB  = 4'h8;
  localparam logic [3:0] SH  = 4'h9;
  localparam logic [3:0] SW  = 4'hA;
  localparam logic [3:0] BAD = 4'hF;

  logic        clk;
  logic        rst;
  logic        v0, v1, r0, r1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, a1, w0, w1;
  logic [4:0]  t0, t1;
  logic        mem_req, mem_we, ack;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_be;
  logic        resp_valid, resp_slot, resp_err;
  logic [4:0]  resp_tag;
  logic [31:0] resp_data;

  lsu_port_arbiter #(
    .AWIDTH(32), .DWIDTH(32), .TWIDTH(5), .OPCODE_WIDTH(4),
    .OP_LOAD_BYTE(LB), .OP_LOAD_HALF(LH), .OP_LOAD_WORD(LW),
    .OP_LOAD_BYTE_UNSIGNED(LBU), .OP_LOAD_HALF_UNSIGNED(LHU),
    .OP_STORE_BYTE(SB), .OP_STORE_HALF(SH), .OP_STORE_WORD(SW)
  ) dut (
    .ls_i_clk(clk), .ls_i_rst(rst),
    .ls_i_valid0(v0), .ls_i_valid1(v1),
    .ls_o_ready0(r0), .ls_o_ready1(r1),
    .ls_i_opcode0(op0), .ls_i_opcode1(op1),
    .ls_i_addr0(a0), .ls_i_addr1(a1),
    .ls_i_wdata0(w0), .ls_i_wdata1(w1),
    .ls_i_tag0(t0), .ls_i_tag1(t1),
    .ls_o_mem_req(mem_req), .ls_o_mem_we(mem_we), .ls_o_mem_addr(mem_addr),
    .ls_o_mem_be(mem_be), .ls_o_mem_wdata(mem_wdata),
    .ls_i_mem_ack(ack), .ls_i_mem_rdata(rdata),
    .ls_o_resp_valid(resp_valid), .ls_o_resp_slot(resp_slot),
    .ls_o_resp_tag(resp_tag), .ls_o_resp_data(resp_data), .ls_o_resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        slot;
    logic [4:0]  tag;
    logic [31:0] data;
    logic        err;
    int          acc_cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_t;

  rsp_t sb[$];
  mem_t memq[$];
  bit   grant_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int resp_cnt = 0;
  int mreq_cnt = 0;
  int lat = 0;
  int wcnt = 0;
  bit auto_ack = 1'b0;
  bit prev_r0 = 1'b0;
  bit prev_r1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa == 32'h100) return 32'h80AB_CDEF;
    return {~wa[15:0], wa[15:0] ^ 16'h5A5A};
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic bit is_bad(input logic [3:0] op, input logic [31:0] a);
    case (op)
      LB, LBU, SB: return 1'b0;
      LH, LHU, SH: return a[0];
      LW, SW:      return a[1:0] != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a[1:0]);
    case (op)
      LB:      return {{24{s[7]}}, s[7:0]};
      LBU:     return {24'h0, s[7:0]};
      LH:      return {{16{s[15]}}, s[15:0]};
      LHU:     return {16'h0, s[15:0]};
      LW:      return s;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
    case (op)
      SB:      return 4'b0001 << a[1:0];
      SH:      return 4'b0011 << a[1:0];
      SW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [3:0] op, input logic [31:0] w);
    case (op)
      SB:      return {4{w[7:0]}};
      SH:      return {2{w[15:0]}};
      SW:      return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic push_req(input bit s, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] w, input logic [4:0] t);
    rsp_t r;
    mem_t m;
    r.slot    = s;
    r.tag     = t;
    r.err     = is_bad(op, a);
    r.data    = (r.err || is_store(op)) ? 32'h0 : exp_load(op, a, rd_word(a));
    r.acc_cyc = cyc;
    sb.push_back(r);
    if (!r.err) begin
      m.addr  = {a[31:2], 2'b00};
      m.we    = is_store(op);
      m.be    = exp_be(op, a);
      m.wdata = exp_wd(op, w);
      memq.push_back(m);
    end
    grant_q.push_back(s);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance monitor: records grants and the expected outcome of each accepted request.
  always @(negedge clk) begin
    if (r0 && r1) chk("ready_both_slots", 32'd1, 32'd0);
    if (r0 && prev_r0) chk("ready0_back_to_back", 32'd1, 32'd0);
    if (r1 && prev_r1) chk("ready1_back_to_back", 32'd1, 32'd0);
    prev_r0 = r0;
    prev_r1 = r1;
    if (v0 && r0) push_req(1'b0, op0, a0, w0, t0);
    if (v1 && r1) push_req(1'b1, op1, a1, w1, t1);
    if (mem_req) mreq_cnt++;
  end

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("resp_slot", 32'(resp_slot), 32'(e.slot));
        chk("resp_tag",  32'(resp_tag),  32'(e.tag));
        chk("resp_data", resp_data,      e.data);
        chk("resp_err",  32'(resp_err),  32'(e.err));
        if (e.err) chk("resp_latency_err", 32'(cyc), 32'(e.acc_cyc + 1));
        else       chk("resp_latency_mem", 32'(cyc), 32'(last_ack_cyc + 1));
        resp_cnt++;
      end
    end
  end

  // Memory model: checks held request fields every cycle and acks after lat waits.
  always @(posedge clk) begin
    #1;
    if (auto_ack) begin
      if (ack) begin
        ack   = 1'b0;
        rdata = $urandom;
      end else if (mem_req) begin
        if (memq.size() == 0) begin
          chk("mem_req_unexpected", 32'd1, 32'd0);
        end else begin
          mem_t m;
          m = memq[0];
          chk("mem_addr",  mem_addr,        m.addr);
          chk("mem_we",    32'(mem_we),     32'(m.we));
          chk("mem_be",    32'(mem_be),     32'(m.be));
          chk("mem_wdata", mem_wdata,       m.wdata);
          if (wcnt >= lat) begin
            ack          = 1'b1;
            rdata        = rd_word(m.addr);
            last_ack_cyc = cyc;
            wcnt         = 0;
            void'(memq.pop_front());
          end else begin
            wcnt++;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic drive(input bit s, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] t, input bit v);
    if (s) begin op1 = op; a1 = a; w1 = w; t1 = t; v1 = v; end
    else   begin op0 = op; a0 = a; w0 = w; t0 = t; v0 = v; end
  endtask

  task automatic do_req(input bit s, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] w, input logic [4:0] t);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    drive(s, op, a, w, t, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s ? r1 : r0) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (s) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && memq.size() == 0 && !mem_req && !resp_valid) begin ok = 1'b1; break; end
    end
    chk("drain_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    bit ok;
    bit s;
    rst = 1'b1; ack = 1'b0; rdata = 32'h0;
    drive(1'b0, LW, 32'h10, 32'h0, 5'd1, 1'b1);
    drive(1'b1, LW, 32'h14, 32'h0, 5'd2, 1'b1);
    auto_ack = 1'b1;

    // reset held two cycles with both slots requesting
    repeat (2) begin
      @(negedge clk);
      chk("reset_ready0",     32'(r0),         32'd0);
      chk("reset_ready1",     32'(r1),         32'd0);
      chk("reset_mem_req",    32'(mem_req),    32'd0);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_mem_misc",   {mem_addr[27:0], mem_be} | mem_wdata | 32'(mem_we), 32'd0);
      chk("reset_resp_misc",  resp_data | 32'({resp_slot, resp_tag, resp_err}), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0 || r1) begin ok = 1'b1; break; end
    end
    chk("first_grant_seen",  32'(ok), 32'd1);
    chk("first_grant_slot0", 32'(r0), 32'd1);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    drain();

    // sub-word loads from the high lane, store half replication
    lat = 3;
    do_req(1'b0, LB,  32'h103, 32'h0, 5'd7);
    drain();
    do_req(1'b0, LBU, 32'h103, 32'h0, 5'd8);
    drain();
    lat = 1;
    do_req(1'b1, SH,  32'h22, 32'h1234_BEEF, 5'd9);
    drain();
    lat = 0;
    do_req(1'b0, LH,  32'h102, 32'h0, 5'd10);
    drain();
    do_req(1'b1, SB,  32'h1, 32'hCAFE_005A, 5'd11);
    drain();

    // both slots continuously valid: grants must alternate starting at slot 0
    @(posedge clk); #1;
    grant_q.delete();
    base = resp_cnt;
    drive(1'b0, LW, 32'h200, 32'h0, 5'd16, 1'b1);
    drive(1'b1, LW, 32'h300, 32'h0, 5'd24, 1'b1);
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (r0 || r1) begin
        s = r1;
        n++;
        @(posedge clk); #1;
        if (n == 4) begin
          v0 = 1'b0; v1 = 1'b0;
        end else if (s) begin
          drive(1'b1, LW, 32'h300 + 32'(4 * n), 32'h0, 5'(24 + n), 1'b1);
        end else begin
          drive(1'b0, LW, 32'h200 + 32'(4 * n), 32'h0, 5'(16 + n), 1'b1);
        end
      end
    end
    chk("alt_accept_count", 32'(n), 32'd4);
    drain();
    chk("alt_grant_count", 32'(grant_q.size()), 32'd4);
    for (int i = 0; i < grant_q.size() && i < 4; i++) begin
      chk("alt_grant_order", 32'(grant_q[i]), 32'(i % 2));
    end
    chk("alt_resp_count", 32'(resp_cnt - base), 32'd4);

    // error requests never reach memory
    base = mreq_cnt;
    do_req(1'b0, LH,  32'h05, 32'h0, 5'd3);
    drain();
    do_req(1'b1, LW,  32'h42, 32'h0, 5'd4);
    drain();
    do_req(1'b0, BAD, 32'h40, 32'h0, 5'd5);
    drain();
    chk("no_mem_req_on_err", 32'(mreq_cnt), 32'(base));

    // reset while waiting for ack, then a stray ack in IDLE
    auto_ack = 1'b0;
    base = resp_cnt;
    do_req(1'b0, LW, 32'h40, 32'h0, 5'd13);
    @(negedge clk);
    chk("mem_req_before_abort", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, LW, 32'h50, 32'h0, 5'd14, 1'b1);
    @(posedge clk); #1;
    sb.delete(); memq.delete();
    @(negedge clk);
    chk("abort_mem_req",    32'(mem_req),    32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_ready1",     32'(r1),         32'd0);
    @(posedge clk); #1;
    rst = 1'b0; v1 = 1'b0;
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stray_ack_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_ack_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("abort_resp_count", 32'(resp_cnt - base), 32'd0);

    auto_ack = 1'b1;
    lat = 2;
    @(posedge clk); #1;
    drive(1'b1, LHU, 32'h42, 32'h0, 5'd12, 1'b1);
    @(negedge clk);
    chk("ready_after_abort", 32'(r1), 32'd1);
    @(posedge clk); #1;
    v1 = 1'b0;
    drain();
    chk("post_abort_resp_count", 32'(resp_cnt - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
